// File: rtl/fifo_reader_pkg.sv
// rtl/fifo_reader_pkg.sv - shared FSM state type and default widths for fifo_reader
package fifo_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LEN_WIDTH  = 8;
    localparam int STALL_CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// rtl/fifo_reader_skid.sv - two-entry in-order skid buffer between FIFO read data and the output stream
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_ok;
    logic                  push_ok;

    // Next-state for the two slots; head is always the oldest entry
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop_i && (count_q != 2'd0);
        push_ok = push_i && ((count_q != 2'd2) || pop_ok);
        case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Slot and occupancy registers; reset empties the buffer and zeroes the output word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign pop_data_o = head_q;
    assign count_o    = count_q;

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - burst FIFO drainer onto a valid/ready stream; FIFO_READER_STATS_EN adds stall_cnt_o
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                       clk_r,
    input  logic                       arst,
    input  logic                       start_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    input  logic                       fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]      fifo_data_i,
    output logic                       fifo_re_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [DATA_WIDTH-1:0]      m_data_o,
    output logic                       busy_o,
`ifdef FIFO_READER_STATS_EN
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o,
`endif
    output logic                       done_o
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_e               state_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic                 inflight_q;
    logic                 busy_q;
    logic                 done_q;
    logic [1:0]           occ;
    logic                 pop;
    logic                 slot_free;
    logic                 buf_drains;

    assign pop = m_valid_o && m_ready_i;

    // The entry leaving this cycle counts as free, so reads stream at one word per cycle when unstalled
    assign slot_free  = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign fifo_re_o  = (state_q == ST_RUN) && !fifo_empty_i && (remaining_q != '0) && slot_free;

    // Buffer will be empty after this edge, so DONE follows the last transfer by one cycle
    assign buf_drains = !inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    // Burst FSM with read bookkeeping and registered busy/done flags
    always_ff @(posedge clk_r or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= fifo_re_o;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (len_i != '0) begin
                            state_q     <= ST_RUN;
                            remaining_q <= len_i;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (fifo_re_o) begin
                        remaining_q <= remaining_q - LEN_ONE;
                        if (remaining_q == LEN_ONE) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (buf_drains) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk_r),
        .rst_i       (arst),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_i),
        .pop_i       (pop),
        .pop_data_o  (m_data_o),
        .count_o     (occ)
    );

    assign m_valid_o = (occ != 2'd0);
    assign busy_o    = busy_q;
    assign done_o    = done_q;

`ifdef FIFO_READER_STATS_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    // Saturating count of back-pressured cycles, restarted by each accepted burst
    always_ff @(posedge clk_r or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            stall_cnt_q <= '0;
        end else if (m_valid_o && !m_ready_i && (stall_cnt_q != {STALL_CNT_WIDTH{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed self-checking bench for fifo_reader with a transaction-level model
module tb_fifo_reader;

    logic        clk_r = 1'b0;
    logic        arst;
    logic        start_i;
    logic [7:0]  len_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;
    logic        fifo_re_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_data_o;
    logic        busy_o;
    logic        done_o;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] stall_cnt_o;
`endif

    fifo_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk_r        (clk_r),
        .arst         (arst),
        .start_i      (start_i),
        .len_i        (len_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_re_o    (fifo_re_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .busy_o       (busy_o),
`ifdef FIFO_READER_STATS_EN
        .stall_cnt_o  (stall_cnt_o),
`endif
        .done_o       (done_o)
    );

    always #5 clk_r = ~clk_r;

    int checks   = 0;
    int failures = 0;

    // Model state: burst bookkeeping, issue cycles of words not yet delivered, expected word order
    int          cyc;
    bit          in_burst;
    int          reads_left;
    int          burst_len;
    int          xfers;
    int          done_due;
    int          stall_exp;
    int          busy_cycles;
    int          rd_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] fifo_q[$];
    bit          force_empty;
    int          re_log[$];
    int          xfer_cyc[$];
    logic [31:0] xfer_dat[$];
    int          done_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic update_empty();
        fifo_empty_i = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic reset_model();
        in_burst   = 0;
        reads_left = 0;
        burst_len  = 0;
        xfers      = 0;
        done_due   = -1;
        stall_exp  = 0;
        rd_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_logs();
        re_log.delete();
        xfer_cyc.delete();
        xfer_dat.delete();
        done_log.delete();
        busy_cycles = 0;
    endtask

    task automatic load_fifo(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + 32'(i));
        update_empty();
    endtask

    // One clock: compare outputs at the falling edge, then advance the model at the rising edge
    task automatic tick();
        logic        re, v, rd, dn, bz, vexp, accepted;
        logic [31:0] d, word;
        int          outstanding;
        @(negedge clk_r);
        re = fifo_re_o; v = m_valid_o; rd = m_ready_i; d = m_data_o; dn = done_o; bz = busy_o;
        check("busy", bz, in_burst);
        check("done", dn, cyc == done_due);
        vexp = (rd_q.size() > 0) && (rd_q[0] <= cyc - 2);
        check("m_valid", v, vexp);
        if (v && exp_q.size() > 0) check("m_data", d, exp_q[0]);
        if (re) begin
            check("re_while_empty", fifo_empty_i, 1'b0);
            check("re_outside_burst", in_burst && (reads_left > 0), 1'b1);
        end
        outstanding = rd_q.size() + int'(re) - int'(v && rd);
        check("outstanding_le2", outstanding <= 2, 1'b1);
`ifdef FIFO_READER_STATS_EN
        check("stall_cnt", stall_cnt_o, stall_exp);
`endif
        @(posedge clk_r);
        word = 32'hDEAD_BEEF;
        if (re) begin
            re_log.push_back(cyc);
            rd_q.push_back(cyc);
            reads_left--;
            if (fifo_q.size() > 0) word = fifo_q.pop_front();
            exp_q.push_back(word);
        end
        if (v && rd) begin
            xfer_cyc.push_back(cyc);
            xfer_dat.push_back(d);
            if (rd_q.size() > 0) void'(rd_q.pop_front());
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            xfers++;
            if (xfers == burst_len) done_due = cyc + 1;
        end
        if (v && !rd && stall_exp < 65535) stall_exp++;
        if (dn) done_log.push_back(cyc);
        if (bz) busy_cycles++;
        accepted = start_i && !in_burst;
        if (cyc == done_due) in_burst = 0;
        if (accepted) begin
            in_burst   = 1;
            burst_len  = int'(len_i);
            reads_left = int'(len_i);
            xfers      = 0;
            stall_exp  = 0;
            if (len_i == 8'd0) done_due = cyc + 1;
        end
        cyc++;
        #1;
        if (re) begin
            fifo_data_i = word;
            update_empty();
        end
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while (in_burst && n < max_cycles);
        check("burst_timeout", in_burst, 1'b0);
        tick();
    endtask

    task automatic start_burst(input logic [7:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_re"},    fifo_re_o, 1'b0);
        check({tag, "_valid"}, m_valid_o, 1'b0);
        check({tag, "_data"},  m_data_o,  32'h0);
        check({tag, "_busy"},  busy_o,    1'b0);
        check({tag, "_done"},  done_o,    1'b0);
    endtask

    int t0;
    int n;

    initial begin
        arst = 1'b1; start_i = 1'b0; len_i = 8'd0; m_ready_i = 1'b1;
        fifo_data_i = 32'h0; force_empty = 0; cyc = 0;
        update_empty();
        reset_model();
        clear_logs();
        #12;
        check_zero_outputs("reset");
        @(posedge clk_r); #1;
        arst = 1'b0;
        tick();

        // Burst of 4 with ready high; a stray start mid-burst must be ignored
        clear_logs();
        load_fifo(32'hA1, 4);
        t0 = cyc;
        start_burst(8'd4);
        tick(); tick();
        start_i = 1'b1; len_i = 8'd9;
        tick();
        start_i = 1'b0;
        run_until_idle(40);
        check("t1_reads", re_log.size(), 4);
        for (int i = 0; i < 4 && i < re_log.size(); i++) check("t1_re_cycle", re_log[i], t0 + 1 + i);
        check("t1_xfers", xfer_dat.size(), 4);
        for (int i = 0; i < 4 && i < xfer_dat.size(); i++) begin
            check("t1_data", xfer_dat[i], 32'hA1 + 32'(i));
            check("t1_xfer_cycle", xfer_cyc[i], t0 + 3 + i);
        end
        check("t1_done_count", done_log.size(), 1);
        if (done_log.size() > 0) check("t1_done_cycle", done_log[0], t0 + 7);

        // Burst of 3 with 5 stalled cycles after the first valid
        clear_logs();
        load_fifo(32'hA1, 3);
        start_burst(8'd3);
        n = 0;
        while (!m_valid_o && n < 10) begin tick(); n++; end
        check("t2_valid_seen", m_valid_o, 1'b1);
        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_A1", m_data_o, 32'hA1);
            tick();
        end
        check("t2_reads_during_stall", re_log.size(), 2);
        m_ready_i = 1'b1;
        run_until_idle(30);
        check("t2_xfers", xfer_dat.size(), 3);
        for (int i = 0; i < 3 && i < xfer_dat.size(); i++) check("t2_data", xfer_dat[i], 32'hA1 + 32'(i));
        check("t2_done_count", done_log.size(), 1);

        // Burst of 2 with the FIFO empty for 6 cycles
        clear_logs();
        force_empty = 1;
        update_empty();
        start_burst(8'd2);
        for (int i = 0; i < 6; i++) begin
            check("t3_busy", busy_o, 1'b1);
            check("t3_no_re", fifo_re_o, 1'b0);
            tick();
        end
        force_empty = 0;
        load_fifo(32'hB1, 2);
        run_until_idle(30);
        check("t3_reads", re_log.size(), 2);
        check("t3_xfers", xfer_dat.size(), 2);
        for (int i = 0; i < 2 && i < xfer_dat.size(); i++) check("t3_data", xfer_dat[i], 32'hB1 + 32'(i));

        // Zero-length burst
        clear_logs();
        t0 = cyc;
        start_burst(8'd0);
        run_until_idle(5);
        check("t4_busy_cycles", busy_cycles, 1);
        check("t4_done_count", done_log.size(), 1);
        if (done_log.size() > 0) check("t4_done_cycle", done_log[0], t0 + 1);
        check("t4_reads", re_log.size(), 0);

        // Reset after 2 of 5 words, then a clean single-word burst
        clear_logs();
        load_fifo(32'hC1, 5);
        start_burst(8'd5);
        n = 0;
        while (xfers < 2 && n < 20) begin tick(); n++; end
        check("t5_two_xfers", xfers, 2);
        #2;
        arst = 1'b1;
        #1;
        check_zero_outputs("t5_async");
        reset_model();
        fifo_q.delete();
        update_empty();
        @(posedge clk_r); #1;
        cyc++;
        arst = 1'b0;
        clear_logs();
        tick(); tick(); tick();
        check("t5_no_done", done_log.size(), 0);
        load_fifo(32'hD1, 1);
        start_burst(8'd1);
        run_until_idle(20);
        check("t5_xfers", xfer_dat.size(), 1);
        if (xfer_dat.size() > 0) check("t5_data", xfer_dat[0], 32'hD1);
        check("t5_done_count", done_log.size(), 1);

`ifdef FIFO_READER_STATS_EN
        // Seven stalled cycles, then the count restarts on the next accepted burst
        clear_logs();
        load_fifo(32'hE1, 2);
        start_burst(8'd2);
        n = 0;
        while (!m_valid_o && n < 10) begin tick(); n++; end
        m_ready_i = 1'b0;
        repeat (7) tick();
        m_ready_i = 1'b1;
        check("t6_stall_7", stall_cnt_o, 16'd7);
        run_until_idle(20);
        check("t6_stall_kept", stall_cnt_o, 16'd7);
        start_burst(8'd0);
        check("t6_stall_cleared", stall_cnt_o, 16'd0);
        run_until_idle(5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk_r and arst. No other clock or reset is permitted.
REQ-002 Parameter DATA_WIDTH, default 32: width of FIFO words and stream data.
REQ-003 Parameter LEN_WIDTH, default 8: width of the burst length.
REQ-004 clk_r  input  1: read-domain clock; all state changes on its rising edge.
REQ-005 arst  input  1: asynchronous reset, active-high.
REQ-006 start_i  input  1: single-cycle burst request, sampled in IDLE only.
REQ-007 len_i  input  LEN_WIDTH: number of words to drain, sampled with start_i.
REQ-008 fifo_empty_i  input  1: FIFO read-side empty flag.
REQ-009 fifo_data_i  input  DATA_WIDTH: FIFO read data, valid one cycle after fifo_re_o.
REQ-010 fifo_re_o  output  1: FIFO read enable.
REQ-011 m_valid_o, m_ready_i, m_data_o  output/input/output  1/1/DATA_WIDTH: downstream valid/ready stream.
REQ-012 busy_o  output  1: high in any state other than IDLE.
REQ-013 done_o  output  1: single-cycle pulse at burst completion.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FLUSH, DONE, encoded in fifo_reader_pkg.
REQ-015 IDLE + start_i with len_i!=0 -> RUN, with remaining count loaded from len_i; len_i==0 -> DONE directly.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 In RUN, fifo_re_o SHALL be 1 iff !fifo_empty_i, remaining>0, and (buffer occupancy + in-flight reads) < 2. Each asserted cycle decrements remaining by 1.
REQ-018 A read issued in cycle N SHALL capture fifo_data_i at edge N+1 into a 2-entry skid buffer. Back-to-back reads at 1 word/cycle SHALL be sustained while m_ready_i=1.
REQ-019 RUN -> FLUSH when the last read is issued. FLUSH -> DONE when the buffer is empty and no read is in flight.
REQ-020 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-021 m_valid_o SHALL be 1 iff the buffer holds at least one entry. m_data_o SHALL be the oldest entry. A transfer occurs when m_valid_o and m_ready_i are both 1.
REQ-022 While m_valid_o=1 and m_ready_i=0, m_data_o SHALL remain stable, and no entry SHALL be dropped or duplicated.
REQ-023 fifo_re_o SHALL never assert in IDLE, FLUSH or DONE, or while fifo_empty_i=1 (no underflow).
REQ-024 Words SHALL be delivered in FIFO order, exactly len_i per burst.
REQ-025 Remaining-count arithmetic SHALL be unsigned LEN_WIDTH and SHALL never wrap below 0.

Reset
REQ-026 When arst is asserted, the block SHALL immediately enter IDLE, clear remaining, empty the buffer, and discard any in-flight read.
REQ-027 Output values during reset: fifo_re_o=0, m_valid_o=0, m_data_o=0, busy_o=0, done_o=0.
REQ-028 Reset asserted mid-burst SHALL NOT produce a done_o pulse. The first start_i after release SHALL behave identically to start_i after power-up.

Configuration
REQ-029 Macro FIFO_READER_STATS_EN, when defined, SHALL add output stall_cnt_o (16 bits).
- Counts cycles with m_valid_o=1 and m_ready_i=0.
- Saturates at 16'hFFFF.
- Cleared on an accepted start_i and on arst.
REQ-030 Without FIFO_READER_STATS_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package fifo_reader_pkg SHALL hold the FSM state enum typedef and the default DATA_WIDTH/LEN_WIDTH constants.
REQ-032 The 2-entry buffer SHALL be the sub-module fifo_reader_skid, with push/pop/count ports. The FSM and read issue logic SHALL stay in fifo_reader.

Verification
REQ-033 Burst len_i=4, FIFO holds 0xA1..0xA4, m_ready_i=1: fifo_re_o high 4 consecutive cycles, and m_data_o = A1,A2,A3,A4 on consecutive cycles. done_o is one pulse one cycle after the last transfer.
REQ-034 len_i=3 with m_ready_i=0 for 5 cycles after the first valid: at most 2 reads are outstanding, m_data_o holds 0xA1, and all 3 words arrive in order after ready rises.
REQ-035 len_i=2, fifo_empty_i=1 for 6 cycles, then 2 words arrive: no fifo_re_o while empty, busy_o=1 throughout, and both words are delivered.
REQ-036 len_i=0: busy_o is high for one cycle (DONE), done_o pulses, and fifo_re_o is never asserted.
REQ-037 arst asserted after 2 of 5 words of a burst: all outputs go to 0 asynchronously, no done_o occurs, and a subsequent len_i=1 burst completes normally.
REQ-038 With FIFO_READER_STATS_EN defined, 7 stall cycles give stall_cnt_o=7, and the count resets to 0 on the next accepted start_i.
